// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory stage: memory op encoding, LSU FSM states
// and the except_type bit positions raised on address errors.
package mips_mem_pkg;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      LB   = 4'd1,
      LBU  = 4'd2,
      LH   = 4'd3,
      LHU  = 4'd4,
      LW   = 4'd5,
      SB   = 4'd6,
      SH   = 4'd7,
      SW   = 4'd8
   } mem_op_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      DISCARD
   } lsu_state_t;

   localparam int ADEL_BIT = 12;
   localparam int ADES_BIT = 13;

   function automatic logic is_load(input mem_op_t op);
      return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / lane replication and
// load byte/half extraction with sign or zero extension. Purely combinational.
module lsu_align
   import mips_mem_pkg::*;
(
   input  mem_op_t     op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rbyte   = rdata_i[8*off_i +: 8];
      rhalf   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      be_o    = 4'hF;
      wdata_o = sdata_i;
      ldata_o = rdata_i;
      case (op_i)
         LB, LBU, SB: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{sdata_i[7:0]}};
         end
         LH, LHU, SH: begin
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{sdata_i[15:0]}};
         end
         default: ;
      endcase
      case (op_i)
         LB:      ldata_o = {{24{rbyte[7]}}, rbyte};
         LBU:     ldata_o = {24'b0, rbyte};
         LH:      ldata_o = {{16{rhalf[15]}}, rhalf};
         LHU:     ldata_o = {16'b0, rhalf};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MIPS MEM stage: loads/stores over an addr_ok/data_ok bus; result lands on the
// data_ok cycle, stall_req holds upstream while an access is outstanding.
module mem_lsu
   import mips_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [3:0]  memop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic        whilo_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_waddr_i,
   input  logic [31:0] cp0_data_i,
   input  logic [31:0] except_type_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        data_req,
   output logic        data_wr,
   output logic [3:0]  data_be,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        stall_req,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_data_o,
   output logic [31:0] except_type_o,
   output logic [31:0] bad_vaddr_o
);

   lsu_state_t  state_q, state_d;
   mem_op_t     op, op_q, cur_op;
   logic [31:0] addr_q, wdata_q, buf_q;
   logic        flush_q, flush_d;
   logic        ld, st, mis, op_ok, req, stall, done_now, sup, fl, use_q;
   logic [31:0] exc_gen;
   logic [1:0]  cur_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_ldata;

   assign op      = mem_op_t'(memop_i);
   assign ld      = is_load(op);
   assign st      = is_store(op);
   assign use_q   = (state_q != IDLE);
   assign cur_op  = use_q ? op_q : op;
   assign cur_off = use_q ? addr_q[1:0] : mem_addr_i[1:0];
   assign fl      = flush_i | flush_q;

   always_comb begin
      mis = 1'b0;
      case (op)
         LH, LHU, SH: mis = valid_i & mem_addr_i[0];
         LW, SW:      mis = valid_i & (|mem_addr_i[1:0]);
         default:     mis = 1'b0;
      endcase
      exc_gen = except_type_i;
      if (mis && ld) exc_gen[ADEL_BIT] = 1'b1;
      if (mis && st) exc_gen[ADES_BIT] = 1'b1;
   end

   assign op_ok = valid_i & (ld | st) & ~(|exc_gen);

   lsu_align u_align (
      .op_i    (cur_op),
      .off_i   (cur_off),
      .sdata_i (store_data_i),
      .rdata_i (data_rdata),
      .be_o    (al_be),
      .wdata_o (al_wdata),
      .ldata_o (al_ldata)
   );

   // An orphaned access (flushed after issue) still owns the bus: any new mem op
   // waits, and its writes are held off until it can actually issue.
   always_comb begin
      state_d  = state_q;
      flush_d  = 1'b0;
      req      = 1'b0;
      stall    = 1'b0;
      done_now = 1'b0;
      sup      = flush_i;
      case (state_q)
         IDLE: if (!flush_i && op_ok) begin
            req = 1'b1;
            if (data_addr_ok && data_data_ok) begin
               done_now = 1'b1;
               state_d  = stall_i ? DONE : IDLE;
            end else begin
               stall   = 1'b1;
               state_d = data_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            req      = 1'b1;
            flush_d  = fl & ~data_addr_ok;
            done_now = data_addr_ok & data_data_ok & ~fl;
            if (data_addr_ok && data_data_ok) state_d = (fl || !stall_i) ? IDLE : DONE;
            else if (data_addr_ok)            state_d = fl ? DISCARD : WAIT;
            if (flush_q) begin
               stall = op_ok & ~flush_i;
               sup   = flush_i | op_ok;
            end else begin
               stall = ~flush_i & ~(data_addr_ok & data_data_ok);
            end
         end
         WAIT: begin
            stall = ~flush_i & ~data_data_ok;
            if (data_data_ok) begin
               done_now = ~flush_i;
               state_d  = (flush_i || !stall_i) ? IDLE : DONE;
            end else if (flush_i) begin
               state_d = DISCARD;
            end
         end
         DONE: if (flush_i || !stall_i) state_d = IDLE;
         DISCARD: begin
            stall = op_ok & ~flush_i;
            sup   = flush_i | op_ok;
            if (data_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         flush_q <= 1'b0;
         op_q    <= NONE;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         buf_q   <= 32'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         if (state_q == IDLE && req) begin
            op_q    <= op;
            addr_q  <= mem_addr_i;
            wdata_q <= al_wdata;
         end
         if (done_now) buf_q <= al_ldata;
      end
   end

   logic wen_ok;
   assign wen_ok = rst & ~(|exc_gen) & ~sup;

   assign data_req      = rst & req;
   assign data_wr       = rst & req & is_store(cur_op);
   assign data_be       = (rst && req) ? al_be : 4'b0;
   assign data_addr     = !rst ? 32'b0 :
                          use_q ? {addr_q[31:2], 2'b00} : {mem_addr_i[31:2], 2'b00};
   assign data_wdata    = !rst ? 32'b0 : (state_q == REQ) ? wdata_q : al_wdata;
   assign stall_req     = rst & stall;
   assign wd_o          = rst ? wd_i : 5'b0;
   assign wreg_o        = wen_ok & wreg_i;
   assign wdata_o       = !rst ? 32'b0 :
                          (done_now && is_load(cur_op)) ? al_ldata :
                          (state_q == DONE && is_load(op_q)) ? buf_q : wdata_i;
   assign whilo_o       = wen_ok & whilo_i;
   assign hi_o          = rst ? hi_i : 32'b0;
   assign lo_o          = rst ? lo_i : 32'b0;
   assign cp0_we_o      = wen_ok & cp0_we_i;
   assign cp0_waddr_o   = rst ? cp0_waddr_i : 5'b0;
   assign cp0_data_o    = rst ? cp0_data_i : 32'b0;
   assign except_type_o = rst ? exc_gen : 32'b0;
   assign bad_vaddr_o   = (rst && mis) ? mem_addr_i : 32'b0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle vector table plus hand sequences for
// delayed handshakes, DONE hold, flushes and reset mid-access.
`timescale 1ns/1ps
module tb_mem_lsu;
   import mips_mem_pkg::*;

   localparam logic [31:0] W = 32'h1111_1111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, valid_i, wreg_i, whilo_i, cp0_we_i, stall_i, flush_i;
   logic [3:0]  memop_i;
   logic [31:0] mem_addr_i, store_data_i, wdata_i, hi_i, lo_i, cp0_data_i, except_type_i;
   logic [4:0]  wd_i, cp0_waddr_i;
   logic        data_req, data_wr, data_addr_ok, data_data_ok, stall_req;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [4:0]  wd_o, cp0_waddr_o;
   logic        wreg_o, whilo_o, cp0_we_o;
   logic [31:0] wdata_o, hi_o, lo_o, cp0_data_o, except_type_o, bad_vaddr_o;

   mem_lsu dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i),
      .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
      .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_data_i(cp0_data_i),
      .except_type_i(except_type_i), .stall_i(stall_i), .flush_i(flush_i),
      .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .stall_req(stall_req),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
      .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o),
      .except_type_o(except_type_o), .bad_vaddr_o(bad_vaddr_o)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic setop(input mem_op_t o, input logic [31:0] a);
      memop_i    = o;
      mem_addr_i = a;
   endtask

   function automatic logic [31:0] wen3();
      return {29'b0, wreg_o, whilo_o, cp0_we_o};
   endfunction

   typedef struct {
      mem_op_t     op;
      logic [31:0] addr, sdata, rdata, exc_in;
      logic        req, wr;
      logic [3:0]  be;
      logic [31:0] baddr, bwdata, wdo, exc_o, bad;
      logic        wen;
   } vec_t;

   vec_t vt [17];

   initial begin
      vt[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'h0,   1, 0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,    32'h0,   1};
      vt[1]  = '{LB,  32'h103, 32'h0,        32'h80FFFF7F, 32'h0,   1, 0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80, 32'h0,    32'h0,   1};
      vt[2]  = '{LB,  32'h103, 32'h0,        32'h80000000, 32'h0,   1, 0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80, 32'h0,    32'h0,   1};
      vt[3]  = '{LBU, 32'h103, 32'h0,        32'h80000000, 32'h0,   1, 0, 4'h8, 32'h100, 32'h0,        32'h00000080, 32'h0,    32'h0,   1};
      vt[4]  = '{LHU, 32'h102, 32'h0,        32'h80000000, 32'h0,   1, 0, 4'hC, 32'h100, 32'h0,        32'h00008000, 32'h0,    32'h0,   1};
      vt[5]  = '{LH,  32'h102, 32'h0,        32'h80000000, 32'h0,   1, 0, 4'hC, 32'h100, 32'h0,        32'hFFFF8000, 32'h0,    32'h0,   1};
      vt[6]  = '{LB,  32'h100, 32'h0,        32'h0000007F, 32'h0,   1, 0, 4'h1, 32'h100, 32'h0,        32'h0000007F, 32'h0,    32'h0,   1};
      vt[7]  = '{LH,  32'h100, 32'h0,        32'h00008001, 32'h0,   1, 0, 4'h3, 32'h100, 32'h0,        32'hFFFF8001, 32'h0,    32'h0,   1};
      vt[8]  = '{SH,  32'h206, 32'h1234ABCD, 32'h0,        32'h0,   1, 1, 4'hC, 32'h204, 32'hABCDABCD, W,            32'h0,    32'h0,   1};
      vt[9]  = '{SB,  32'h201, 32'h000000A5, 32'h0,        32'h0,   1, 1, 4'h2, 32'h200, 32'hA5A5A5A5, W,            32'h0,    32'h0,   1};
      vt[10] = '{SW,  32'h200, 32'hCAFEF00D, 32'h0,        32'h0,   1, 1, 4'hF, 32'h200, 32'hCAFEF00D, W,            32'h0,    32'h0,   1};
      vt[11] = '{LW,  32'h101, 32'h0,        32'h0,        32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        W,            32'h1000, 32'h101, 0};
      vt[12] = '{SH,  32'h207, 32'h0,        32'h0,        32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        W,            32'h2000, 32'h207, 0};
      vt[13] = '{LH,  32'h101, 32'h0,        32'h0,        32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        W,            32'h1000, 32'h101, 0};
      vt[14] = '{NONE,32'h101, 32'h0,        32'h0,        32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        W,            32'h0,    32'h0,   1};
      vt[15] = '{LW,  32'h104, 32'h0,        32'h0,        32'h400, 0, 0, 4'h0, 32'h0,   32'h0,        W,            32'h400,  32'h0,   0};
      vt[16] = '{SB,  32'h203, 32'h0000005A, 32'h0,        32'h0,   1, 1, 4'h8, 32'h200, 32'h5A5A5A5A, W,            32'h0,    32'h0,   1};

      rst = 1'b0; valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      wd_i = 5'd7; wreg_i = 1'b1; wdata_i = W; whilo_i = 1'b1; hi_i = 32'hA; lo_i = 32'hB;
      cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_data_i = 32'hC; except_type_i = 32'h0;
      store_data_i = 32'h0; data_rdata = 32'h0;
      setop(LW, 32'h100); data_addr_ok = 1'b1; data_data_ok = 1'b1;

      // reset: everything forced low
      @(negedge clk);
      chk("rst_req", {31'b0, data_req}, 0);
      chk("rst_stall", {31'b0, stall_req}, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_wen", wen3(), 0);
      chk("rst_wd", {27'b0, wd_o}, 0);
      nxt();
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         setop(vt[i].op, vt[i].addr);
         store_data_i  = vt[i].sdata;
         data_rdata    = vt[i].rdata;
         except_type_i = vt[i].exc_in;
         data_addr_ok  = 1'b1;
         data_data_ok  = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'b0, data_req}, {31'b0, vt[i].req});
         chk($sformatf("v%0d_wr", i), {31'b0, data_wr}, {31'b0, vt[i].wr});
         chk($sformatf("v%0d_stall", i), {31'b0, stall_req}, 0);
         chk($sformatf("v%0d_wdata_o", i), wdata_o, vt[i].wdo);
         chk($sformatf("v%0d_wen", i), wen3(), vt[i].wen ? 32'd7 : 32'd0);
         chk($sformatf("v%0d_exc", i), except_type_o, vt[i].exc_o);
         chk($sformatf("v%0d_bad", i), bad_vaddr_o, vt[i].bad);
         if (vt[i].req) begin
            chk($sformatf("v%0d_be", i), {28'b0, data_be}, {28'b0, vt[i].be});
            chk($sformatf("v%0d_addr", i), data_addr, vt[i].baddr);
         end
         if (vt[i].wr) chk($sformatf("v%0d_bwdata", i), data_wdata, vt[i].bwdata);
         nxt();
      end
      except_type_i = 32'h0;

      // LW: addr_ok now, data_ok two cycles later
      setop(LW, 32'h100); data_addr_ok = 1'b1; data_data_ok = 1'b0;
      @(negedge clk);
      chk("b_req0", {31'b0, data_req}, 1);
      chk("b_stall0", {31'b0, stall_req}, 1);
      nxt();
      data_addr_ok = 1'b0;
      @(negedge clk);
      chk("b_req1", {31'b0, data_req}, 0);
      chk("b_stall1", {31'b0, stall_req}, 1);
      nxt();
      data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("b_stall2", {31'b0, stall_req}, 0);
      chk("b_wdata", wdata_o, 32'hDEADBEEF);
      chk("b_wreg", {31'b0, wreg_o}, 1);
      nxt();
      data_data_ok = 1'b0; setop(NONE, 32'h0);

      // addr_ok delayed three cycles, data_ok under stall_i
      setop(LW, 32'h108);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("c_req%0d", c), {31'b0, data_req}, 1);
         chk($sformatf("c_addr%0d", c), data_addr, 32'h108);
         chk($sformatf("c_be%0d", c), {28'b0, data_be}, 32'hF);
         chk($sformatf("c_stall%0d", c), {31'b0, stall_req}, 1);
         nxt();
      end
      data_addr_ok = 1'b1;
      @(negedge clk);
      chk("c_req3", {31'b0, data_req}, 1);
      nxt();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12345678; stall_i = 1'b1;
      @(negedge clk);
      chk("c_dok_wdata", wdata_o, 32'h12345678);
      chk("c_dok_stall", {31'b0, stall_req}, 0);
      nxt();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      @(negedge clk);
      chk("c_done_wdata", wdata_o, 32'h12345678);
      chk("c_done_req", {31'b0, data_req}, 0);
      chk("c_done_stall", {31'b0, stall_req}, 0);
      nxt();
      stall_i = 1'b0;
      @(negedge clk);
      chk("c_done_last", wdata_o, 32'h12345678);
      nxt();
      setop(NONE, 32'h0);
      @(negedge clk);
      chk("c_idle_wdata", wdata_o, W);
      chk("c_idle_req", {31'b0, data_req}, 0);
      nxt();

      // flush in WAIT, then a new LW must wait for the stale data_ok
      setop(LW, 32'h10C); data_addr_ok = 1'b1;
      nxt();
      data_addr_ok = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      chk("d_flush_wen", wen3(), 0);
      chk("d_flush_stall", {31'b0, stall_req}, 0);
      nxt();
      flush_i = 1'b0; setop(LW, 32'h110);
      @(negedge clk);
      chk("d_disc_req", {31'b0, data_req}, 0);
      chk("d_disc_stall", {31'b0, stall_req}, 1);
      nxt();
      data_data_ok = 1'b1; data_rdata = 32'hBADBAD00;
      @(negedge clk);
      chk("d_stale_req", {31'b0, data_req}, 0);
      chk("d_stale_wdata", wdata_o, W);
      chk("d_stale_stall", {31'b0, stall_req}, 1);
      nxt();
      data_addr_ok = 1'b1; data_rdata = 32'h00000042;
      @(negedge clk);
      chk("d_new_req", {31'b0, data_req}, 1);
      chk("d_new_addr", data_addr, 32'h110);
      chk("d_new_wdata", wdata_o, 32'h42);
      chk("d_new_stall", {31'b0, stall_req}, 0);
      nxt();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; setop(NONE, 32'h0);

      // flush in REQ: request held until accepted, then discarded
      setop(LW, 32'h114);
      nxt();
      flush_i = 1'b1;
      @(negedge clk);
      chk("f_req_flush", {31'b0, data_req}, 1);
      chk("f_addr_flush", data_addr, 32'h114);
      nxt();
      flush_i = 1'b0; setop(NONE, 32'h0); data_addr_ok = 1'b1;
      @(negedge clk);
      chk("f_req_held", {31'b0, data_req}, 1);
      chk("f_addr_held", data_addr, 32'h114);
      chk("f_stall", {31'b0, stall_req}, 0);
      nxt();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFEEDFACE;
      @(negedge clk);
      chk("f_disc_wdata", wdata_o, W);
      chk("f_disc_req", {31'b0, data_req}, 0);
      nxt();
      data_data_ok = 1'b0;

      // reset in the middle of an access
      setop(LW, 32'h118);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("e_rst_req", {31'b0, data_req}, 0);
      chk("e_rst_stall", {31'b0, stall_req}, 0);
      nxt();
      rst = 1'b1; setop(NONE, 32'h0);
      @(negedge clk);
      chk("e_idle_req", {31'b0, data_req}, 0);
      chk("e_idle_stall", {31'b0, stall_req}, 0);
      nxt();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
